// File: rtl/aes_inv_shift_row_stream.sv
// Word-serial AES (Inv)ShiftRows stage.
// Four 32-bit column words are collected into one of two ping-pong banks;
// once a bank is full, its permuted columns are streamed out one per beat
// while the other bank fills. Column byte order: [31:24]=row0 .. [7:0]=row3.
module aes_inv_shift_row_stream #(
    parameter bit INV = 1'b1   // 1: InvShiftRows, 0: forward ShiftRows
) (
    input  logic        clk,
    input  logic        g_rst_n,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_last,
    output logic        done,
    output logic        busy
);

    // Bank storage: bank_q[bank][column]; contents need no reset.
    logic [31:0] bank_q [2][4];

    logic [1:0]  full_q, full_d;
    logic        wp_q, wp_d;
    logic        rp_q, rp_d;
    logic [1:0]  wcnt_q, wcnt_d;
    logic [1:0]  rcnt_q, rcnt_d;
    logic        in_ready_q, in_ready_d;
    logic        done_q, done_d;

    logic        wr_fire;
    logic        rd_fire;
    logic [31:0] perm_word;

    assign wr_fire = in_valid && in_ready_q;
    assign rd_fire = out_valid && out_ready;

    // Next-state for bank flags, pointers and beat counters.
    // The write side only touches bank wp and the read side only bank rp;
    // since wp==rp implies that bank is either full or not, both sides can
    // update full_d in the same cycle without conflict.
    always_comb begin
        full_d = full_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        done_d = 1'b0;
        if (wr_fire) begin
            wcnt_d = wcnt_q + 2'd1;
            if (wcnt_q == 2'd3) begin
                full_d[wp_q] = 1'b1;
                wp_d         = ~wp_q;
            end
        end
        if (rd_fire) begin
            rcnt_d = rcnt_q + 2'd1;
            if (rcnt_q == 2'd3) begin
                full_d[rp_q] = 1'b0;
                rp_d         = ~rp_q;
                done_d       = 1'b1;
            end
        end
        // Registered ready: look ahead at the bank the write pointer will
        // address next, so a bank freed this cycle is writable immediately.
        in_ready_d = !full_d[wp_d];
    end

    // Control state register; reset and abort flush identically.
    always_ff @(posedge clk) begin
        if (!g_rst_n || abort) begin
            full_q     <= '0;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            full_q     <= full_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
        end
    end

    // Capture accepted column words into the current write bank.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank_q[wp_q][wcnt_q] <= in_word;
        end
    end

    // Row r of output column c comes from stored column c-r (inverse)
    // or c+r (forward), modulo 4.
    always_comb begin
        perm_word = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            perm_word[31-8*r -: 8] =
                bank_q[rp_q][INV ? (rcnt_q - 2'(r)) : (rcnt_q + 2'(r))][31-8*r -: 8];
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = full_q[rp_q];
    assign out_word  = out_valid ? perm_word : '0;
    assign out_last  = out_valid && (rcnt_q == 2'd3);
    assign done      = done_q;
    assign busy      = (|full_q) || (wcnt_q != 2'd0);

endmodule

// File: tb/tb_aes_inv_shift_row_stream.sv
// Directed and randomised bench for aes_inv_shift_row_stream.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_aes_inv_shift_row_stream;

    logic        clk = 1'b0;
    logic        rst_n, abort;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, done, busy;
    logic [31:0] in_word, out_word;

    logic        f_in_valid, f_in_ready, f_out_valid, f_out_last, f_done, f_busy;
    logic [31:0] f_in_word, f_out_word;
    logic        r_in_ready, r_out_valid, r_out_ready, r_out_last, r_done, r_busy;
    logic [31:0] r_out_word;

    int checks = 0;
    int fails  = 0;

    logic [31:0] VIN_A [4] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
    logic [31:0] EXP_A [4] = '{32'h000D0A07, 32'h04010E0B, 32'h0805020F, 32'h0C090603};
    logic [31:0] VIN_B [4] = '{32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F};
    logic [31:0] EXP_B [4] = '{32'h101D1A17, 32'h14111E1B, 32'h1815121F, 32'h1C191613};
    logic [31:0] VIN_C [4] = '{32'hA0B0C0D0, 32'hA1B1C1D1, 32'hA2B2C2D2, 32'hA3B3C3D3};
    logic [31:0] EXP_C [4] = '{32'hA0B3C2D1, 32'hA1B0C3D2, 32'hA2B1C0D3, 32'hA3B2C1D0};

    always #5 clk = ~clk;

    aes_inv_shift_row_stream #(.INV(1'b1)) dut (
        .clk(clk), .g_rst_n(rst_n), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_last(out_last), .done(done), .busy(busy)
    );

    // Forward stage feeding an inverse stage: should reproduce the input.
    aes_inv_shift_row_stream #(.INV(1'b0)) u_fwd (
        .clk(clk), .g_rst_n(rst_n), .abort(abort),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .in_word(f_in_word),
        .out_valid(f_out_valid), .out_ready(r_in_ready), .out_word(f_out_word),
        .out_last(f_out_last), .done(f_done), .busy(f_busy)
    );

    aes_inv_shift_row_stream #(.INV(1'b1)) u_rt (
        .clk(clk), .g_rst_n(rst_n), .abort(abort),
        .in_valid(f_out_valid), .in_ready(r_in_ready), .in_word(f_out_word),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_word(r_out_word),
        .out_last(r_out_last), .done(r_done), .busy(r_busy)
    );

    // Reference InvShiftRows: state matrix s[row][col], out[r][c] = s[r][(c-r) mod 4].
    function automatic logic [31:0] model_col(input logic [127:0] blk, input int c);
        logic [7:0]  s [4][4];
        logic [31:0] w;
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            w = blk[32*k +: 32];
            for (int r = 0; r < 4; r++) s[r][k] = w[31-8*r -: 8];
        end
        res = '0;
        for (int r = 0; r < 4; r++) res[31-8*r -: 8] = s[r][(c - r + 4) % 4];
        return res;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %b exp 0", out_last); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b exp 0", done); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (out_word !== 32'h0) begin fails++; $display("FAIL reset_out_word: got %h exp 0", out_word); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b exp 1", in_ready); end
        checks++; if (f_in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_fwd_in_ready: got %b exp 1", f_in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_out_valid: got %b exp 0", out_valid); end
    endtask

    task automatic test_inv_basic();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_word  = VIN_A[k];
            checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready[%0d]: got %b exp 1", k, in_ready); end
            checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid[%0d]: got %b exp 0", k, out_valid); end
            if (k > 0) begin
                checks++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy[%0d]: got %b exp 1", k, busy); end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_out_valid[%0d]: got %b exp 1", k, out_valid); end
            checks++; if (out_word !== EXP_A[k]) begin fails++; $display("FAIL basic_out_word[%0d]: got %h exp %h", k, out_word, EXP_A[k]); end
            checks++; if (out_last !== (k == 3)) begin fails++; $display("FAIL basic_out_last[%0d]: got %b exp %b", k, out_last, (k == 3)); end
            checks++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_early[%0d]: got %b exp 0", k, done); end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL basic_done_pulse: got %b exp 1", done); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drained: got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle_busy: got %b exp 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_width: got %b exp 0", done); end
        out_ready = 1'b0;
    endtask

    task automatic test_fwd_roundtrip();
        int  i = 0;
        int  got = 0;
        bit  seen_first = 1'b0;
        bit  acc;
        r_out_ready = 1'b1;
        for (int n = 0; n < 40 && got < 4; n++) begin
            f_in_valid = (i < 4);
            f_in_word  = (i < 4) ? VIN_A[i] : 32'h0;
            acc = f_in_valid && f_in_ready;
            if (f_out_valid && !seen_first) begin
                seen_first = 1'b1;
                checks++; if (f_out_word !== 32'h00050A0F) begin fails++; $display("FAIL fwd_first_word: got %h exp 00050a0f", f_out_word); end
            end
            if (r_out_valid) begin
                checks++; if (r_out_word !== VIN_A[got]) begin fails++; $display("FAIL roundtrip_word[%0d]: got %h exp %h", got, r_out_word, VIN_A[got]); end
                got++;
            end
            @(negedge clk);
            if (acc) i++;
        end
        f_in_valid  = 1'b0;
        r_out_ready = 1'b0;
        checks++; if (seen_first !== 1'b1) begin fails++; $display("FAIL fwd_output_timeout: got %b exp 1", seen_first); end
        checks++; if (got !== 4) begin fails++; $display("FAIL roundtrip_count: got %0d exp 4", got); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] bin  [12];
        logic [31:0] bexp [12];
        for (int k = 0; k < 4; k++) begin
            bin[k]   = VIN_A[k]; bexp[k]   = EXP_A[k];
            bin[k+4] = VIN_B[k]; bexp[k+4] = EXP_B[k];
            bin[k+8] = VIN_C[k]; bexp[k+8] = EXP_C[k];
        end
        out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            in_valid = (n < 12);
            in_word  = (n < 12) ? bin[n] : 32'h0;
            if (n < 12) begin
                checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready[%0d]: got %b exp 1", n, in_ready); end
            end
            checks++; if (out_valid !== (n >= 4 && n < 16)) begin fails++; $display("FAIL b2b_out_valid[%0d]: got %b exp %b", n, out_valid, (n >= 4 && n < 16)); end
            if (n >= 4 && n < 16) begin
                checks++; if (out_word !== bexp[n-4]) begin fails++; $display("FAIL b2b_out_word[%0d]: got %h exp %h", n, out_word, bexp[n-4]); end
                checks++; if (out_last !== ((n - 4) % 4 == 3)) begin fails++; $display("FAIL b2b_out_last[%0d]: got %b exp %b", n, out_last, ((n - 4) % 4 == 3)); end
            end
            checks++; if (done !== (n == 8 || n == 12 || n == 16)) begin fails++; $display("FAIL b2b_done[%0d]: got %b exp %b", n, done, (n == 8 || n == 12 || n == 16)); end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] win [8];
        logic [31:0] dexp [8];
        int i = 0;
        bit acc;
        for (int k = 0; k < 4; k++) begin
            win[k] = VIN_A[k]; dexp[k]   = EXP_A[k];
            win[k+4] = VIN_B[k]; dexp[k+4] = EXP_B[k];
        end
        out_ready = 1'b0;
        for (int n = 0; n < 12; n++) begin
            in_valid = 1'b1;
            in_word  = (i < 8) ? win[i] : 32'hDEADBEEF;
            checks++; if (in_ready !== (n < 8)) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b exp %b", n, in_ready, (n < 8)); end
            if (n >= 4) begin
                checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid[%0d]: got %b exp 1", n, out_valid); end
                checks++; if (out_word !== EXP_A[0]) begin fails++; $display("FAIL bp_hold_word[%0d]: got %h exp %h", n, out_word, EXP_A[0]); end
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) i++;
        end
        checks++; if (i !== 8) begin fails++; $display("FAIL bp_accept_count: got %0d exp 8", i); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_drain_valid[%0d]: got %b exp 1", k, out_valid); end
            checks++; if (out_word !== dexp[k]) begin fails++; $display("FAIL bp_drain_word[%0d]: got %h exp %h", k, out_word, dexp[k]); end
            checks++; if (out_last !== (k % 4 == 3)) begin fails++; $display("FAIL bp_drain_last[%0d]: got %b exp %b", k, out_last, (k % 4 == 3)); end
            checks++; if (in_ready !== (k >= 4)) begin fails++; $display("FAIL bp_drain_in_ready[%0d]: got %b exp %b", k, in_ready, (k >= 4)); end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: got %b exp 0", out_valid); end
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL bp_done: got %b exp 1", done); end
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midblock(input bit use_abort);
        int i = 0;
        int got = 0;
        bit acc;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_word  = VIN_C[k];
            checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid%0d_in_ready[%0d]: got %b exp 1", use_abort, k, in_ready); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL mid%0d_busy_partial: got %b exp 1", use_abort, busy); end
        if (use_abort) abort = 1'b1; else rst_n = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid%0d_out_valid: got %b exp 0", use_abort, out_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid%0d_busy: got %b exp 0", use_abort, busy); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid%0d_in_ready_flush: got %b exp 0", use_abort, in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid%0d_in_ready_back: got %b exp 1", use_abort, in_ready); end
        for (int n = 0; n < 30 && got < 4; n++) begin
            in_valid = (i < 4);
            in_word  = (i < 4) ? VIN_B[i] : 32'h0;
            acc = in_valid && in_ready;
            if (out_valid) begin
                checks++; if (out_word !== EXP_B[got]) begin fails++; $display("FAIL mid%0d_word[%0d]: got %h exp %h", use_abort, got, out_word, EXP_B[got]); end
                got++;
            end
            @(negedge clk);
            if (acc) i++;
        end
        in_valid = 1'b0;
        checks++; if (got !== 4) begin fails++; $display("FAIL mid%0d_count: got %0d exp 4", use_abort, got); end
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL mid%0d_done: got %b exp 1", use_abort, done); end
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        localparam int NBLK = 1000;
        logic [31:0]  expq [$];
        logic [127:0] blk = '0;
        logic [31:0]  nxt;
        logic [31:0]  e;
        int  sent = 0;
        int  got = 0;
        int  dcount = 0;
        bit  last_prev = 1'b0;
        bit  acc, xfer;
        nxt = $urandom;
        for (int cyc = 0; cyc < 40000 && got < 4*NBLK; cyc++) begin
            in_valid  = (sent < 4*NBLK) && ($urandom_range(0, 1) == 1);
            in_word   = nxt;
            out_ready = ($urandom_range(0, 1) == 1);
            checks++; if (done !== last_prev) begin fails++; $display("FAIL rnd_done[%0d]: got %b exp %b", cyc, done, last_prev); end
            if (done === 1'b1) dcount++;
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            if (xfer) begin
                e = (expq.size() > 0) ? expq.pop_front() : 32'hXXXXXXXX;
                checks++; if (out_word !== e) begin fails++; $display("FAIL rnd_word[%0d]: got %h exp %h", got, out_word, e); end
                checks++; if (out_last !== (got % 4 == 3)) begin fails++; $display("FAIL rnd_last[%0d]: got %b exp %b", got, out_last, (got % 4 == 3)); end
                got++;
            end
            last_prev = xfer && ((got - 1) % 4 == 3);
            @(negedge clk);
            if (acc) begin
                blk[32*(sent % 4) +: 32] = in_word;
                if (sent % 4 == 3) begin
                    for (int c = 0; c < 4; c++) expq.push_back(model_col(blk, c));
                end
                sent++;
                nxt = $urandom;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (done !== last_prev) begin fails++; $display("FAIL rnd_done_tail: got %b exp %b", done, last_prev); end
        if (done === 1'b1) dcount++;
        checks++; if (got !== 4*NBLK) begin fails++; $display("FAIL rnd_word_count: got %0d exp %0d", got, 4*NBLK); end
        checks++; if (dcount !== NBLK) begin fails++; $display("FAIL rnd_done_count: got %0d exp %0d", dcount, NBLK); end
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        abort       = 1'b0;
        in_valid    = 1'b0;
        in_word     = '0;
        out_ready   = 1'b0;
        f_in_valid  = 1'b0;
        f_in_word   = '0;
        r_out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_inv_basic();
        test_fwd_roundtrip();
        test_back_to_back();
        test_backpressure();
        test_reset_midblock(1'b0);
        test_reset_midblock(1'b1);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
